mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single decoupled memory port between instruction fetch (IF, read-only) and the load/store execution unit (LS).
- Grants one request per cycle, records the issuer of each accepted request in an in-order tracking FIFO, and routes each in-order response back to its issuer.
- On pipeline flush, discards responses to fetches already in flight.
- Sits between the fetch and mem execution units and the memory port.

Parameters:
- DEPTH, 2, max outstanding memory transactions (tracking FIFO entries); power of two, >=1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_req_valid  in  1  fetch request valid
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_a  in  32  fetch word address (bits 1:0 are 00)
- if_resp_valid  out  1  fetch response valid, no backpressure
- if_resp_data  out  32  fetch response word
- ls_req_valid  in  1  LS request valid
- ls_req_ready  out  1  LS request accepted this cycle
- ls_req_a  in  32  LS word-aligned address
- ls_req_we  in  1  LS write enable
- ls_req_be  in  4  LS byte enables
- ls_req_d  in  32  LS write data
- ls_resp_valid  out  1  LS response valid, no backpressure
- ls_resp_data  out  32  LS response word
- flush  in  1  pipeline flush; kills in-flight fetches
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_a  out  32  memory address
- mem_req_we  out  1  memory write enable
- mem_req_be  out  4  memory byte enables
- mem_req_d  out  32  memory write data
- mem_resp_valid  in  1  memory response valid, in request order
- mem_resp_data  in  32  memory response word
- mem_resp_ready  out  1  tied 1

Behaviour:
- Reset (rst_n low, async):
  - FIFO empty, count 0.
  - Round-robin pointer = LS.
  - All valid/ready outputs 0 while in reset.
- Issue (combinational, zero latency):
  - can_issue = count < DEPTH. Pushes and pops happen in the same cycle; a push is never bypassed on a full FIFO that is popping.
  - Grant selects among valid requesters. mem_req_valid = can_issue && (if_req_valid || ls_req_valid).
  - mem_req_* carry the granted payload.
  - For an IF grant: mem_req_we=0, mem_req_be=4'b1111, mem_req_d=0.
  - For an LS grant: ls_req_* pass through unchanged.
  - Granted requester's ready = mem_req_ready && can_issue. The ungranted requester's ready = 0.
  - The grant must not change while mem_req_valid is high and mem_req_ready is low; grant is held until that request fires.
- Tracking FIFO:
  - Entry = {src (0=IF, 1=LS), drop}. Push on mem_req fire; drop = flush && src==IF.
  - On mem_resp_valid, pop the head.
  - Head src=LS: ls_resp_valid=1. Head src=IF and !drop: if_resp_valid=1. Routing is combinational in the same cycle.
  - Both *_resp_data = mem_resp_data, gated to 0 when the corresponding valid is low.
  - Simultaneous push and pop: count unchanged, both pointers advance, wrap modulo DEPTH.
  - mem_resp_valid with the FIFO empty is a protocol error: ignore it, no output; a simulation assertion fires.
- Flush:
  - Sets drop on every valid IF entry, including one pushed in the same cycle.
  - If flush coincides with a pop of an IF head, that response is suppressed.
  - LS entries are never dropped; the LS request in flight completes normally.
  - Flush does not block issue.
- A pending (held) IF grant at flush is still issued when it fires, and is marked drop.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - When both requesters are valid, grant goes to the side the pointer names.
  - On every fire the pointer moves to the side not just granted.
- MEM_ARB_RR_EN undefined: fixed priority, LS wins whenever ls_req_valid is high; the pointer is absent.
- The hold-while-stalled rule applies in both builds.

Test Plan:
- IF-only read: if_req a=0x100 with mem_req_ready=1, response 0xDEADBEEF 2 cycles later -> mem_req_a=0x100, we=0, be=1111; if_resp_valid=1 with 0xDEADBEEF; ls_resp_valid=0.
- Contention, fixed-priority build: both valid for 4 cycles, mem_req_ready=1 -> four LS grants, if_req_ready=0 throughout. RR build -> grant order LS, IF, LS, IF.
- Full FIFO, DEPTH=2: two requests accepted with no response -> third sees if/ls_req_ready=0 and mem_req_valid=0. Response in the next cycle plus a new request -> accepted the following cycle, count back to 2.
- Flush kill: IF request then LS request outstanding, flush pulsed -> IF response suppressed (if_resp_valid stays 0); LS response 0x12345678 delivered on ls_resp.
- Stall hold: both valid, mem_req_ready=0 for 3 cycles -> mem_req_a/we/be/d stable and grant unchanged until fire.
- Async reset mid-operation: rst_n low with 2 outstanding -> count 0 immediately. A later mem_resp_valid is ignored and the assertion fires.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, routing in-order responses back.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise LS has fixed priority.
module mem_port_arbiter #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req_valid,
   output logic        if_req_ready,
   input  logic [31:0] if_req_a,
   output logic        if_resp_valid,
   output logic [31:0] if_resp_data,
   input  logic        ls_req_valid,
   output logic        ls_req_ready,
   input  logic [31:0] ls_req_a,
   input  logic        ls_req_we,
   input  logic [3:0]  ls_req_be,
   input  logic [31:0] ls_req_d,
   output logic        ls_resp_valid,
   output logic [31:0] ls_resp_data,
   input  logic        flush,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_a,
   output logic        mem_req_we,
   output logic [3:0]  mem_req_be,
   output logic [31:0] mem_req_d,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic        mem_resp_ready
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [DEPTH-1:0] src_q, src_d, drop_q, drop_d;
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             stall_q, stall_d, stall_src_q, stall_src_d, kill_q, kill_d;
   logic             can_issue, arb_ls, gnt_ls, fire, pop, head_src, head_drop;

`ifdef MEM_ARB_RR_EN
   logic rr_q, rr_d;
   assign arb_ls = ls_req_valid && (!if_req_valid || rr_q);
   assign rr_d   = fire ? !gnt_ls : rr_q;
`else
   assign arb_ls = ls_req_valid;
`endif

   // A stalled grant is held as long as its requester keeps asking
   assign gnt_ls    = (stall_q && (stall_src_q ? ls_req_valid : if_req_valid)) ? stall_src_q : arb_ls;
   assign can_issue = rst_n && cnt_q < FULL;
   assign fire      = mem_req_valid && mem_req_ready;
   assign pop       = mem_resp_valid && cnt_q != '0;
   assign head_src  = src_q[rd_q];
   assign head_drop = drop_q[rd_q] || flush;

   assign mem_req_valid  = can_issue && (if_req_valid || ls_req_valid);
   assign mem_req_a      = gnt_ls ? ls_req_a : if_req_a;
   assign mem_req_we     = gnt_ls && ls_req_we;
   assign mem_req_be     = gnt_ls ? ls_req_be : 4'hf;
   assign mem_req_d      = gnt_ls ? ls_req_d : '0;
   assign mem_resp_ready = 1'b1;
   assign if_req_ready   = fire && !gnt_ls;
   assign ls_req_ready   = fire && gnt_ls;
   assign if_resp_valid  = pop && !head_src && !head_drop;
   assign ls_resp_valid  = pop && head_src;
   assign if_resp_data   = if_resp_valid ? mem_resp_data : '0;
   assign ls_resp_data   = ls_resp_valid ? mem_resp_data : '0;

   always_comb begin
      src_d  = src_q;
      drop_d = drop_q | (flush ? ~src_q : '0);
      if (fire) begin
         src_d[wr_q]  = gnt_ls;
         drop_d[wr_q] = (flush || kill_q) && !gnt_ls;
      end
      wr_d        = fire ? (wr_q == LAST ? '0 : wr_q + 1'b1) : wr_q;
      rd_d        = pop ? (rd_q == LAST ? '0 : rd_q + 1'b1) : rd_q;
      cnt_d       = cnt_q + CW'(fire) - CW'(pop);
      stall_d     = mem_req_valid && !mem_req_ready;
      stall_src_d = gnt_ls;
      kill_d      = stall_d && !gnt_ls && (flush || kill_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_q       <= '0;
         drop_q      <= '0;
         wr_q        <= '0;
         rd_q        <= '0;
         cnt_q       <= '0;
         stall_q     <= 1'b0;
         stall_src_q <= 1'b0;
         kill_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
         rr_q        <= 1'b1;
`endif
      end else begin
         src_q       <= src_d;
         drop_q      <= drop_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         cnt_q       <= cnt_d;
         stall_q     <= stall_d;
         stall_src_q <= stall_src_d;
         kill_q      <= kill_d;
`ifdef MEM_ARB_RR_EN
         rr_q        <= rr_d;
`endif
      end
   end

   a_resp_with_empty_fifo: assert property (@(posedge clk) disable iff (!rst_n)
      !(mem_resp_valid && cnt_q == '0));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random stimulus against a queue-based model of the arbiter.
module tb_mem_port_arbiter;
   localparam int DEPTH = 2;

   logic        clk = 1'b0, rst_n;
   logic        if_req_valid, if_req_ready, if_resp_valid;
   logic [31:0] if_req_a, if_resp_data;
   logic        ls_req_valid, ls_req_ready, ls_req_we, ls_resp_valid;
   logic [31:0] ls_req_a, ls_req_d, ls_resp_data;
   logic [3:0]  ls_req_be, mem_req_be;
   logic        flush, mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid, mem_resp_ready;
   logic [31:0] mem_req_a, mem_req_d, mem_resp_data;

   mem_port_arbiter #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_a(if_req_a),
      .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
      .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_a(ls_req_a),
      .ls_req_we(ls_req_we), .ls_req_be(ls_req_be), .ls_req_d(ls_req_d),
      .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data), .flush(flush),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_a(mem_req_a),
      .mem_req_we(mem_req_we), .mem_req_be(mem_req_be), .mem_req_d(mem_req_d),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_ready(mem_resp_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic src; logic drop;} ent_t;
   ent_t q[$];
   logic pend, pend_src, pend_kill, rr, fired_if, fired_ls, if_rdy_seen, ls_rdy_seen;
   int   n_tests, n_fail;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      pend = 1'b0; pend_src = 1'b0; pend_kill = 1'b0; rr = 1'b1;
   endtask

   // One cycle: called at negedge, drives inputs, checks outputs, advances the model at posedge
   task automatic step(input logic iv, input logic [31:0] ia, input logic lv, input logic [31:0] la,
                       input logic lwe, input logic [3:0] lbe, input logic [31:0] ld,
                       input logic mr, input logic rv, input logic [31:0] rdat, input logic fl);
      logic g, ev, pop, eif, els, kill_now;
      if_req_valid = iv; if_req_a = ia;
      ls_req_valid = lv; ls_req_a = la; ls_req_we = lwe; ls_req_be = lbe; ls_req_d = ld;
      mem_req_ready = mr; mem_resp_valid = rv; mem_resp_data = rdat; flush = fl;
      #1;
      if (pend && (pend_src ? lv : iv)) g = pend_src;
`ifdef MEM_ARB_RR_EN
      else g = (iv && lv) ? rr : lv;
`else
      else g = lv;
`endif
      ev  = (q.size() < DEPTH) && (iv || lv);
      pop = rv && q.size() > 0;
      eif = pop && !q[0].src && !q[0].drop && !fl;
      els = pop && q[0].src;
      chk("mem_req_valid", mem_req_valid, ev);
      if (ev) begin
         chk("mem_req_a", mem_req_a, g ? la : ia);
         chk("mem_req_we", mem_req_we, g ? lwe : 1'b0);
         chk("mem_req_be", mem_req_be, g ? lbe : 4'hf);
         chk("mem_req_d", mem_req_d, g ? ld : 32'h0);
      end
      chk("if_req_ready", if_req_ready, ev && mr && !g);
      chk("ls_req_ready", ls_req_ready, ev && mr && g);
      chk("if_resp_valid", if_resp_valid, eif);
      chk("if_resp_data", if_resp_data, eif ? rdat : 32'h0);
      chk("ls_resp_valid", ls_resp_valid, els);
      chk("ls_resp_data", ls_resp_data, els ? rdat : 32'h0);
      chk("mem_resp_ready", mem_resp_ready, 1'b1);
      if_rdy_seen = if_req_ready;
      ls_rdy_seen = ls_req_ready;
      @(posedge clk);
      kill_now = (fl || pend_kill) && !g;
      if (fl) foreach (q[i]) if (!q[i].src) q[i].drop = 1'b1;
      if (pop) void'(q.pop_front());
      fired_if = ev && mr && !g;
      fired_ls = ev && mr && g;
      if (ev && mr) begin
         q.push_back('{src: g, drop: kill_now});
         rr = !g;
      end
      pend      = ev && !mr;
      pend_src  = g;
      pend_kill = ev && !mr && kill_now;
      @(negedge clk);
   endtask

   task automatic drain();
      while (q.size() > 0) step(0, 0, 0, 0, 0, 4'h0, 0, 1, 1, $urandom, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int n_ls, n_if;
      logic ion, lon, lwe;
      logic [31:0] ia, la, ld;
      logic [3:0] lbe;
      n_tests = 0; n_fail = 0;
      model_reset();
      rst_n = 1'b0;
      if_req_valid = 1; if_req_a = 'h100; ls_req_valid = 1; ls_req_a = 'h200;
      ls_req_we = 1; ls_req_be = 4'hf; ls_req_d = 'h1; flush = 0;
      mem_req_ready = 1; mem_resp_valid = 0; mem_resp_data = 0;
      #3;
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_if_req_ready", if_req_ready, 0);
      chk("rst_ls_req_ready", ls_req_ready, 0);
      chk("rst_if_resp_valid", if_resp_valid, 0);
      chk("rst_ls_resp_valid", ls_resp_valid, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // IF-only read, response two cycles later
      step(1, 'h100, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 4'h0, 0, 1, 1, 'hDEADBEEF, 0);

      // Contention for four cycles
      n_ls = 0; n_if = 0;
      for (int k = 0; k < 4; k++) begin
         step(1, 'h200, 1, 'h300 + 4 * k, k[0], 4'h3, 'h55 + k, 1, q.size() > 0, $urandom, 0);
         n_ls += int'(ls_rdy_seen);
         n_if += int'(if_rdy_seen);
      end
`ifdef MEM_ARB_RR_EN
      chk("contention_ls_grants", n_ls, 2);
      chk("contention_if_grants", n_if, 2);
`else
      chk("contention_ls_grants", n_ls, 4);
      chk("contention_if_grants", n_if, 0);
`endif
      drain();

      // Full FIFO: third request blocked, popped slot reusable only the cycle after
      step(1, 'h400, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0);
      step(1, 'h404, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0);
      step(1, 'h408, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0);
      step(1, 'h408, 0, 0, 0, 4'h0, 0, 1, 1, 'h11, 0);
      step(1, 'h408, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0);
      drain();

      // Flush kills the outstanding fetch, LS completes
      step(1, 'h500, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 'h600, 0, 4'hf, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 1);
      step(0, 0, 0, 0, 0, 4'h0, 0, 1, 1, 'hCAFEF00D, 0);
      step(0, 0, 0, 0, 0, 4'h0, 0, 1, 1, 'h12345678, 0);

      // Stall hold: held IF grant survives LS arrival and a flush, then fires dropped
      step(1, 'h700, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
      step(1, 'h700, 1, 'h800, 1, 4'h5, 'hA5A5A5A5, 0, 0, 0, 1);
      step(1, 'h700, 1, 'h800, 1, 4'h5, 'hA5A5A5A5, 0, 0, 0, 0);
      step(1, 'h700, 1, 'h800, 1, 4'h5, 'hA5A5A5A5, 1, 0, 0, 0);
      step(0, 0, 1, 'h800, 1, 4'h5, 'hA5A5A5A5, 0, 0, 0, 0);
      step(0, 0, 1, 'h800, 1, 4'h5, 'hA5A5A5A5, 0, 0, 0, 0);
      step(0, 0, 1, 'h800, 1, 4'h5, 'hA5A5A5A5, 1, 1, 'h77, 0);
      drain();

      // Async reset with two outstanding
      step(1, 'h900, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 'hA00, 0, 4'hf, 0, 1, 0, 0, 0);
      if_req_valid = 1; ls_req_valid = 1; mem_req_ready = 1;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_mem_req_valid", mem_req_valid, 0);
      chk("arst_if_req_ready", if_req_ready, 0);
      chk("arst_ls_req_ready", ls_req_ready, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 'hB00, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0);
      step(1, 'hB04, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0);
      step(1, 'hB08, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0);
      drain();

      // Random traffic; requesters hold valid and payload until accepted
      ion = 0; lon = 0; ia = 0; la = 0; ld = 0; lwe = 0; lbe = 0;
      for (int c = 0; c < 1500; c++) begin
         if (!ion && $urandom_range(0, 2) == 0) begin
            ion = 1; ia = $urandom & 32'hFFFF_FFFC;
         end
         if (!lon && $urandom_range(0, 2) == 0) begin
            lon = 1; la = $urandom & 32'hFFFF_FFFC; ld = $urandom;
            lwe = 1'($urandom); lbe = 4'($urandom);
         end
         step(ion, ia, lon, la, lwe, lbe, ld, $urandom_range(0, 3) != 0,
              q.size() > 0 && $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 9) == 0);
         if (fired_if) ion = 0;
         if (fired_ls) lon = 0;
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
